// File: rtl/led_pkg.sv
// Shared types for the LED pulser: per-channel mode encoding and channel FSM states.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_STRETCH = 2'd1,
        LED_BLINK   = 2'd2,
        LED_ON      = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_BLINK_ON  = 2'd2,
        ST_BLINK_OFF = 2'd3
    } led_state_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: turns a trigger strobe into a stretched pulse or a blink burst.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | nothing running; led follows the static mode (ON=1, else 0)
// ST_STRETCH   | retriggerable pulse, cnt counts remaining ticks
// ST_BLINK_ON  | burst flash lit, cnt counts remaining on-ticks
// ST_BLINK_OFF | burst gap, cnt counts remaining off-ticks, flashes left
module led_channel
    import led_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int HOLD   = 50,
    parameter int PERIOD = 10,
    parameter int BLINKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_trigger,
    input  logic [1:0] i_mode,
    output logic       o_led,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] C_BLINKS = CNT_W'(BLINKS);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    led_state_e       r_state, w_state_nxt;
    led_mode_e        r_mode_q, w_mode;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_flashes, w_flashes_nxt;
    logic             r_led, r_busy;
    logic             w_led_nxt, w_busy_nxt;
    logic             w_mode_chg, w_cnt_last;

    assign w_mode     = led_mode_e'(i_mode);
    assign w_mode_chg = (w_mode != r_mode_q);
    assign w_cnt_last = (r_cnt == C_ONE);

    // State, counters, registered mode and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mode_q  <= LED_OFF;
            r_cnt     <= '0;
            r_flashes <= '0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode_q  <= w_mode;
            r_cnt     <= w_cnt_nxt;
            r_flashes <= w_flashes_nxt;
            r_led     <= w_led_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and counter update; a mode change swallows that cycle's trigger
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_flashes_nxt = r_flashes;
        if (w_mode_chg) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_flashes_nxt = '0;
        end else begin
            case (r_mode_q)
                LED_STRETCH: begin
                    if (i_trigger) begin
                        w_state_nxt = ST_STRETCH;
                        w_cnt_nxt   = C_HOLD;
                    end else if (r_state == ST_STRETCH && i_tick) begin
                        w_cnt_nxt = r_cnt - C_ONE;
                        if (w_cnt_last) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                LED_BLINK: begin
                    case (r_state)
                        ST_IDLE: begin
                            if (i_trigger) begin
                                w_state_nxt   = ST_BLINK_ON;
                                w_cnt_nxt     = C_PERIOD;
                                w_flashes_nxt = C_BLINKS;
                            end
                        end
                        ST_BLINK_ON: begin
                            if (i_tick) begin
                                if (w_cnt_last) begin
                                    w_state_nxt = ST_BLINK_OFF;
                                    w_cnt_nxt   = C_PERIOD;
                                end else begin
                                    w_cnt_nxt = r_cnt - C_ONE;
                                end
                            end
                        end
                        ST_BLINK_OFF: begin
                            if (i_tick) begin
                                if (!w_cnt_last) begin
                                    w_cnt_nxt = r_cnt - C_ONE;
                                end else if (r_flashes == C_ONE) begin
                                    w_state_nxt   = ST_IDLE;
                                    w_cnt_nxt     = '0;
                                    w_flashes_nxt = '0;
                                end else begin
                                    w_state_nxt   = ST_BLINK_ON;
                                    w_cnt_nxt     = C_PERIOD;
                                    w_flashes_nxt = r_flashes - C_ONE;
                                end
                            end
                        end
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so led/busy move on the same edge as the state
    always_comb begin
        w_led_nxt  = (w_state_nxt == ST_STRETCH) || (w_state_nxt == ST_BLINK_ON) ||
                     (w_mode == LED_ON);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign o_led  = r_led;
    assign o_busy = r_busy;

endmodule

// File: rtl/led_pulser.sv
// Multi-channel LED pulser: shared tick prescaler feeding CH independent channels.
module led_pulser
    import led_pkg::*;
#(
    parameter int CH       = 4,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1,
    parameter int HOLD     = 50,
    parameter int PERIOD   = 10,
    parameter int BLINKS   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   trigger,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   led,
    output logic [CH-1:0]   busy
);

    localparam int             PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    // Free-running prescaler; with PRESCALE=1 it sits at 0 and ticks every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        led_channel #(
            .CNT_W  (CNT_W),
            .HOLD   (HOLD),
            .PERIOD (PERIOD),
            .BLINKS (BLINKS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_trigger (trigger[g]),
            .i_mode    (mode[2*g+1:2*g]),
            .o_led     (led[g]),
            .o_busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_led_pulser.sv
// Directed bench for led_pulser: scoreboard of expected led/busy per edge,
// plus a second instance with a slow prescaler for tick-phase checks.
module tb_led_pulser;
    import led_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] trig_a;
    logic [7:0] mode_a;
    logic [3:0] led_a, busy_a;
    logic [0:0] trig_b;
    logic [1:0] mode_b;
    logic [0:0] led_b, busy_b;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [3:0] busy;
    } exp_t;

    exp_t q[$];
    int   len_q[$];

    led_pulser #(.CH(4), .CNT_W(8), .PRESCALE(1), .HOLD(5), .PERIOD(2), .BLINKS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .trigger(trig_a), .mode(mode_a), .led(led_a), .busy(busy_a)
    );

    led_pulser #(.CH(1), .CNT_W(8), .PRESCALE(4), .HOLD(3), .PERIOD(2), .BLINKS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .trigger(trig_b), .mode(mode_b), .led(led_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [3:0] l, input logic [3:0] b);
        exp_t e;
        e.tag  = tag;
        e.led  = l;
        e.busy = b;
        q.push_back(e);
    endtask

    task automatic push_n(input string tag, input int n, input logic [3:0] l, input logic [3:0] b);
        for (int i = 0; i < n; i++) push(tag, l, b);
    endtask

    task automatic check_now();
        exp_t e;
        n_assert++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: got led/busy %b/%b, required an expectation entry", led_a, busy_a);
        end else begin
            e = q.pop_front();
            assert ({led_a, busy_a} === {e.led, e.busy}) else begin
                n_fail++;
                $error("FAIL %s: led/busy got %b/%b required %b/%b", e.tag, led_a, busy_a, e.led, e.busy);
            end
        end
    endtask

    task automatic step(input logic [3:0] trg);
        trig_a = trg;
        @(posedge clk);
        #1;
        trig_a = '0;
        check_now();
    endtask

    task automatic meas_b(output int len);
        trig_b = 1'b1;
        @(posedge clk);
        #1;
        trig_b = 1'b0;
        len = 0;
        while (led_b === 1'b1 && len < 40) begin
            len++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int len;
        int exp_len;

        rst_n  = 1'b0;
        trig_a = '0;
        mode_a = '0;
        trig_b = '0;
        mode_b = LED_OFF;

        #2;
        push("reset", 4'b0000, 4'b0000);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;

        // trigger coincident with a mode change is dropped
        mode_a = 8'b0000_0001;
        push("modechg_trig", 4'b0000, 4'b0000);
        step(4'b0001);
        push("modechg_idle", 4'b0000, 4'b0000);
        step(4'b0000);

        // plain stretch: HOLD edges high
        push_n("stretch", 5, 4'b0001, 4'b0001);
        push("stretch_end", 4'b0000, 4'b0000);
        step(4'b0001);
        repeat (5) step(4'b0000);

        // retrigger three edges later extends to 8 high edges
        push_n("retrig", 8, 4'b0001, 4'b0001);
        push("retrig_end", 4'b0000, 4'b0000);
        step(4'b0001);
        step(4'b0000);
        step(4'b0000);
        step(4'b0001);
        repeat (5) step(4'b0000);

        // retrigger exactly when cnt==1: no low gap
        push_n("reload_last", 10, 4'b0001, 4'b0001);
        push("reload_end", 4'b0000, 4'b0000);
        step(4'b0001);
        repeat (4) step(4'b0000);
        step(4'b0001);
        repeat (5) step(4'b0000);

        // STRETCH -> OFF mid-pulse
        push_n("off_pre", 2, 4'b0001, 4'b0001);
        step(4'b0001);
        step(4'b0000);
        mode_a = 8'b0000_0000;
        push("off_mid", 4'b0000, 4'b0000);
        step(4'b0000);
        push("off_trig", 4'b0000, 4'b0000);
        step(4'b0001);

        // static ON on channel 1
        mode_a = 8'b0000_1100;
        push("on", 4'b0010, 4'b0000);
        step(4'b0000);
        push("on_trig", 4'b0010, 4'b0000);
        step(4'b0010);

        // blink burst on channel 2, with a mid-burst trigger that must be ignored
        mode_a = 8'b0010_1100;
        push("blink_modechg", 4'b0010, 4'b0000);
        step(4'b0100);
        for (int i = 0; i < 8; i++)
            push("blink", ((i % 4) < 2) ? 4'b0110 : 4'b0010, 4'b0100);
        push("blink_end", 4'b0010, 4'b0000);
        push("blink_norestart", 4'b0010, 4'b0000);
        step(4'b0100);
        step(4'b0000);
        step(4'b0000);
        step(4'b0100);
        repeat (6) step(4'b0000);

        // async reset in the middle of bursts on all four channels
        mode_a = 8'b1010_1010;
        push("rst_modechg", 4'b0000, 4'b0000);
        step(4'b0000);
        push("rst_burst", 4'b1111, 4'b1111);
        step(4'b1111);
        push("rst_burst2", 4'b1111, 4'b1111);
        step(4'b0000);
        push("rst_burst_off", 4'b0000, 4'b1111);
        step(4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        push("rst_async", 4'b0000, 4'b0000);
        check_now();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push("rst_first", 4'b0000, 4'b0000);
        step(4'b1111);
        push("rst_idle", 4'b0000, 4'b0000);
        step(4'b0000);
        push("rst_fresh", 4'b1111, 4'b1111);
        step(4'b1111);

        // prescaler: PRESCALE=4, HOLD=3 gives 9..12 high edges depending on tick phase
        mode_b = LED_STRETCH;
        @(posedge clk);
        #1;
        meas_b(len);
        n_assert++;
        assert (len >= 9 && len <= 12) else begin
            n_fail++;
            $error("FAIL presc_first: high edges got %0d required 9..12", len);
        end
        // each fall is on a tick edge, so the prescaler restarts at 0 there;
        // triggering j edges later leaves (4 - j%4) edges to the first tick
        for (int j = 1; j <= 4; j++) begin
            len_q.push_back(8 + 4 - (j % 4));
            repeat (j - 1) begin
                @(posedge clk);
                #1;
            end
            meas_b(len);
            exp_len = len_q.pop_front();
            n_assert++;
            assert (len === exp_len) else begin
                n_fail++;
                $error("FAIL presc_phase%0d: high edges got %0d required %0d", j, len, exp_len);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
